// File: rtl/flipflop_wr_pkg.sv
// Shared constants and helpers for the flipflop_wr write-enabled register.
package flipflop_wr_pkg;

    localparam int FLIPFLOP_WR_DEFAULT_N = 8;
    localparam int FLIPFLOP_WR_MAX_N     = 64;

    // All-zero reset value, sized to the widest legal register and sliced by the user.
    function automatic logic [FLIPFLOP_WR_MAX_N-1:0] zero_reset_val(input int n);
        logic [FLIPFLOP_WR_MAX_N-1:0] val;
        val = '0;
        if (n < 0) val = '0;
        return val;
    endfunction

endpackage

// File: rtl/flipflop_wr.sv
// N-bit register with synchronous active-high reset and write enable.
// Define FLIPFLOP_WR_INIT_EN to power the register up holding RESET_VAL.
module flipflop_wr
    import flipflop_wr_pkg::*;
#(
    parameter int                             N         = FLIPFLOP_WR_DEFAULT_N,
    parameter logic [FLIPFLOP_WR_MAX_N-1:0]   RESET_VAL = zero_reset_val(FLIPFLOP_WR_DEFAULT_N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] p_wr,
    input  logic         wr,
    output logic [N-1:0] q_wr
);

    // RESET_VAL is carried at full width so that bits beyond N can be rejected.
    if (N < 1 || N > FLIPFLOP_WR_MAX_N) begin : g_bad_n
        $error("flipflop_wr: N=%0d outside legal range 1..%0d", N, FLIPFLOP_WR_MAX_N);
    end else if (N < FLIPFLOP_WR_MAX_N) begin : g_chk_rv
        if ((RESET_VAL >> N) != '0) begin : g_bad_rv
            $error("flipflop_wr: RESET_VAL has set bits above bit %0d", N - 1);
        end
    end

    localparam logic [N-1:0] RESET_VAL_N = RESET_VAL[N-1:0];

`ifdef FLIPFLOP_WR_INIT_EN
    logic [N-1:0] q_reg = RESET_VAL_N;
`else
    logic [N-1:0] q_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= RESET_VAL_N;
        end else if (wr) begin
            q_reg <= p_wr;
        end
    end

    assign q_wr = q_reg;

endmodule

// File: tb/tb_flipflop_wr.sv
// Directed self-checking bench for flipflop_wr (N=8, RESET_VAL=0).
module tb_flipflop_wr;

    logic       clk;
    logic       reset;
    logic [7:0] p_wr;
    logic       wr;
    logic [7:0] q_wr;

    int tests_run;
    int tests_failed;

    flipflop_wr #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .p_wr  (p_wr),
        .wr    (wr),
        .q_wr  (q_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: q_wr=0x%02h expected 0x%02h at t=%0t", tag, got, exp, $time);
        end else begin
            $display("[TB] ok   %s: q_wr=0x%02h at t=%0t", tag, got, $time);
        end
    endtask

    // Advance over one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction: apply inputs, cross an edge, compare.
    task automatic xact(input string tag, input logic rst, input logic we,
                        input logic [7:0] d, input logic [7:0] exp);
        reset = rst;
        wr    = we;
        p_wr  = d;
        step();
        check_val(tag, q_wr, exp);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        wr           = 1'b0;
        p_wr         = 8'h00;

`ifdef FLIPFLOP_WR_INIT_EN
        #0;
        check_val("init_t0", q_wr, 8'h00);
`endif

        // Edges at t=5 and t=15 with reset high.
        step();
        xact("reset",       1'b1, 1'b0, 8'h00, 8'h00);

        xact("hold_ac",     1'b0, 1'b0, 8'hAC, 8'h00);
        xact("hold_00",     1'b0, 1'b0, 8'h00, 8'h00);
        xact("hold_ac2",    1'b0, 1'b0, 8'hAC, 8'h00);

        xact("write_cc",    1'b0, 1'b1, 8'hCC, 8'hCC);
        xact("hold_cc_1",   1'b0, 1'b0, 8'hFF, 8'hCC);
        xact("hold_cc_2",   1'b0, 1'b0, 8'hFF, 8'hCC);

        // Inputs wiggled between edges must not reach q_wr.
        #2;
        wr   = 1'b1;
        p_wr = 8'h33;
        #1;
        check_val("no_comb_path", q_wr, 8'hCC);
        wr   = 1'b0;
        p_wr = 8'hFF;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        check_val("no_async_rst", q_wr, 8'hCC);
        xact("rst_glitch",  1'b0, 1'b0, 8'hFF, 8'hCC);

        xact("write_ff",    1'b0, 1'b1, 8'hFF, 8'hFF);

        xact("b2b_11",      1'b0, 1'b1, 8'h11, 8'h11);
        xact("b2b_22",      1'b0, 1'b1, 8'h22, 8'h22);
        xact("b2b_33",      1'b0, 1'b1, 8'h33, 8'h33);
        xact("b2b_80",      1'b0, 1'b1, 8'h80, 8'h80);
        xact("b2b_01",      1'b0, 1'b1, 8'h01, 8'h01);

        xact("rst_over_wr", 1'b1, 1'b1, 8'h5A, 8'h00);
        xact("post_rst_wr", 1'b0, 1'b1, 8'hA5, 8'hA5);
        xact("post_hold",   1'b0, 1'b0, 8'h00, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before t=5000");
        $fatal(1, "watchdog expired");
    end

endmodule
